ahb_master_arbiter: RTL and testbench
=====================================

# ahb_master_arbiter

Shares one AHB master port among `NUM_REQ` local requesters and sequences each granted request as a single AHB transfer (`hburst` = SINGLE). It drives the same `haddr`/`hwdata`/`hburst`/`hsize`/`hwrite`/`htrans` outputs and samples the same `hready`/`hrdata` inputs as the `ahb_vif` master clocking block. It sits between the local request sources and the AHB side of the ahb2apb bridge.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `AHB_AW`, 32: address width.
- `AHB_DW`, 32: data width (32 or 64).

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in `NUM_REQ`: request per requester. Held high until the matching `gnt`.
- `req_addr` in `NUM_REQ*AHB_AW`: packed addresses; requester i occupies slice i.
- `req_write` in `NUM_REQ`: 1 = write, 0 = read.
- `req_size` in `NUM_REQ*3`: packed hsize encodings.
- `req_wdata` in `NUM_REQ*AHB_DW`: packed write data.
- `gnt` out `NUM_REQ`: one-hot, one-cycle accept pulse.
- `done` out `NUM_REQ`: one-hot, one-cycle completion pulse.
- `err` out 1: valid with `done`; the request was rejected and no bus transfer occurred.
- `rdata` out `AHB_DW`: read data, valid with `done` for reads. Holds its value until the next read completes.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `haddr` out `AHB_AW`, `hwdata` out `AHB_DW`, `hburst` out 3, `hsize` out 3, `hwrite` out 1, `htrans` out 2: AHB master outputs.
- `hready` in 1, `hrdata` in `AHB_DW`: AHB master inputs.

## Operation
- FSM states: IDLE, ADDR, DATA. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, pick a winner by round-robin starting at pointer `ptr`.
  - Register the winner's addr/write/size/wdata and pulse `gnt[w]`.
  - Set `ptr` to (w+1) mod `NUM_REQ`.
  - Legal request: go to ADDR.
  - Illegal request (hsize > log2(`AHB_DW`/8), or `haddr` not aligned to the size): pulse `done[w]` and `err` in the cycle after `gnt`, stay in IDLE, and drive nothing on the bus.
- **ADDR**
  - Outputs: `htrans`=NONSEQ, `haddr`/`hsize`/`hwrite` from the registered request, `hburst`=SINGLE.
  - `hready`=1 at the edge: go to DATA.
  - `hready`=0: hold all address-phase outputs unchanged.
- **DATA**
  - Outputs: `htrans`=IDLE; `hwdata` = registered wdata for writes (don't-care for reads).
  - `hready`=1 at the edge: capture `hrdata` into `rdata` if read, pulse `done[w]`, return to IDLE.
  - `hready`=0: hold outputs (wait states, unbounded).
- Only one transfer is outstanding at a time; address and data phases of successive transfers never overlap.
- The `req` inputs of non-winners are ignored until the FSM is next in IDLE.
- Reset values:
  - `htrans`=IDLE, `hburst`=SINGLE(0), all other bus outputs 0.
  - `gnt`, `done`, `err`, `busy` = 0; `rdata` = 0; `ptr` = 0; state = IDLE.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronously). The in-flight transfer is dropped with no `done`, and requesters must re-request.

## Timing
- `req` high at edge k in IDLE gives `gnt` and `htrans`=NONSEQ during cycle k+1.
- With zero wait states:
  - DATA in cycle k+2.
  - `done` in cycle k+3, with `rdata` valid in the same cycle.
  - IDLE again in cycle k+3, so the next `gnt` comes at k+4 at the earliest.
- Minimum period: 3 cycles per transfer; each `hready`-low cycle in ADDR or DATA adds 1.
- A rejected request takes 2 cycles: `gnt` at k+1, `done`+`err` at k+2.
- A requester may re-assert `req` in the cycle after its `done`. It is granted only when its turn comes under round-robin.
- All `req` bits high continuously: grant order is 0,1,2,3,0,...
- `ptr` wraps from `NUM_REQ`-1 to 0.

## Structure
- Package `ahb_pkg` holds:
  - `htrans_t` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - `hburst` constants (SINGLE=0 ... INCR16=7).
  - `hsize` constants (BYTE=0 ... DWORD=3).
  - FSM state enum `arb_state_t`.
- Sub-module `ahb_rr_arbiter` (parameter N; inputs `req`, `ptr`; outputs one-hot `winner` and index). It is purely combinational and reused by the APB side later.
- The top module holds the FSM, request registers, pointer, and legality check.

## Test plan
- Single write, no wait states:
  - Stimulus: req[2] with addr 0x100, size 2 (word), wdata 0xDEADBEEF.
  - Required: `gnt[2]` at k+1, NONSEQ with `haddr`=0x100 at k+1, `hwdata`=0xDEADBEEF at k+2, `done[2]` at k+3, `err`=0.
- Read with wait states:
  - Stimulus: req[0] read at 0x40; slave holds `hready`=0 for 3 DATA cycles, then returns `hrdata`=0x12345678.
  - Required: `done[0]` at k+6, `rdata`=0x12345678, address-phase outputs stable throughout.
- Round-robin fairness:
  - Stimulus: all 4 `req` held high for 12 transfers.
  - Required: grant order 0,1,2,3 repeated 3 times, never back-to-back to the same requester.
- Illegal requests:
  - Stimulus: req[1] with size 3 on a 32-bit bus, then req[1] with addr 0x102 and size 2.
  - Required: each gets `gnt` then `done[1]`+`err` one cycle later, and `htrans` stays IDLE.
- Reset mid-transfer:
  - Stimulus: assert `reset` while in DATA with `hready`=0.
  - Required: `htrans`=IDLE and `busy`=0 asynchronously, no `done` pulse, `ptr`=0 after release.
- Address-phase stall:
  - Stimulus: `hready`=0 for 2 ADDR cycles.
  - Required: NONSEQ, `haddr`, `hsize` and `hwrite` held for 3 cycles, then DATA.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings, arbiter FSM states and transfer legality helper
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // A transfer is legal when its size fits the bus and its address is size-aligned.
    function automatic logic xfer_legal(input logic [2:0] addr_lo,
                                        input logic [2:0] size,
                                        input logic [2:0] max_size);
        logic ok;
        ok = (size <= max_size);
        case (size)
            3'd1:    if (addr_lo[0] != 1'b0) ok = 1'b0;
            3'd2:    if (addr_lo[1:0] != 2'b00) ok = 1'b0;
            3'd3:    if (addr_lo != 3'b000) ok = 1'b0;
            default: ;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - combinational round-robin picker starting at ptr
module ahb_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] winner_idx
);
    localparam int PW = $clog2(N);

    // Scan from the farthest offset down so the candidate closest to ptr wins last.
    always_comb begin
        int c;
        c          = 0;
        winner     = '0;
        winner_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            c = (int'(ptr) + off) % N;
            if (req[c]) begin
                winner     = '0;
                winner[c]  = 1'b1;
                winner_idx = c[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - round-robin sharing of one AHB master port, single transfers
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*AHB_AW-1:0] req_addr,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*3-1:0]    req_size,
    input  logic [NUM_REQ*AHB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic                    err,
    output logic [AHB_DW-1:0]       rdata,
    output logic                    busy,
    output logic [AHB_AW-1:0]       haddr,
    output logic [AHB_DW-1:0]       hwdata,
    output logic [2:0]              hburst,
    output logic [2:0]              hsize,
    output logic                    hwrite,
    output logic [1:0]              htrans,
    input  logic                    hready,
    input  logic [AHB_DW-1:0]       hrdata
);
    localparam int         PW       = $clog2(NUM_REQ);
    localparam logic [2:0] MAX_SIZE = (AHB_DW == 64) ? HSIZE_DWORD : HSIZE_WORD;

    arb_state_t          state;
    logic [PW-1:0]       ptr;
    logic [NUM_REQ-1:0]  cur_oh;
    logic                cur_write;
    logic [AHB_DW-1:0]   cur_wdata;
    logic                rej_pend;

    logic [NUM_REQ-1:0]  win_oh;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       next_ptr;
    logic [AHB_AW-1:0]   sel_addr;
    logic [2:0]          sel_size;
    logic                sel_write;
    logic [AHB_DW-1:0]   sel_wdata;
    logic                sel_legal;

    ahb_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req        (req),
        .ptr        (ptr),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    // Unpack the winner's request fields and precompute its legality and the advanced pointer.
    always_comb begin
        sel_addr  = req_addr[int'(win_idx)*AHB_AW +: AHB_AW];
        sel_size  = req_size[int'(win_idx)*3 +: 3];
        sel_write = req_write[win_idx];
        sel_wdata = req_wdata[int'(win_idx)*AHB_DW +: AHB_DW];
        sel_legal = xfer_legal(sel_addr[2:0], sel_size, MAX_SIZE);
        next_ptr  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Transfer sequencer: grant in IDLE, address phase in ADDR, data phase in DATA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cur_oh    <= '0;
            cur_write <= 1'b0;
            cur_wdata <= '0;
            rej_pend  <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            haddr     <= '0;
            hwdata    <= '0;
            hburst    <= HBURST_SINGLE;
            hsize     <= '0;
            hwrite    <= 1'b0;
            htrans    <= HTRANS_IDLE;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rej_pend) begin
                        // Rejected request completes here; no arbitration this cycle.
                        done     <= cur_oh;
                        err      <= 1'b1;
                        rej_pend <= 1'b0;
                    end else if (|req) begin
                        gnt       <= win_oh;
                        cur_oh    <= win_oh;
                        ptr       <= next_ptr;
                        cur_write <= sel_write;
                        cur_wdata <= sel_wdata;
                        if (sel_legal) begin
                            haddr  <= sel_addr;
                            hsize  <= sel_size;
                            hwrite <= sel_write;
                            hburst <= HBURST_SINGLE;
                            htrans <= HTRANS_NONSEQ;
                            busy   <= 1'b1;
                            state  <= ST_ADDR;
                        end else begin
                            rej_pend <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        hwdata <= cur_wdata;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hready) begin
                        if (!cur_write) rdata <= hrdata;
                        done  <= cur_oh;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed self-checking bench for ahb_master_arbiter
module tb_ahb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*3-1:0]  req_size;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   haddr;
    logic [DW-1:0]   hwdata;
    logic [2:0]      hburst;
    logic [2:0]      hsize;
    logic            hwrite;
    logic [1:0]      htrans;
    logic            hready;
    logic [DW-1:0]   hrdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.NUM_REQ(N), .AHB_AW(AW), .AHB_DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hburst    (hburst),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hready    (hready),
        .hrdata    (hrdata)
    );

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] wdata);
        req_addr[i*AW +: AW]  = addr;
        req_write[i]          = wr;
        req_size[i*3 +: 3]    = size;
        req_wdata[i*DW +: DW] = wdata;
        req[i]                = 1'b1;
    endtask

    // One request with zero wait states; req is set before edge k, checks land in cycles k+1..k+3.
    task automatic run_vec(input vec_t v);
        logic [N-1:0] oh;
        oh = '0;
        oh[v.idx] = 1'b1;
        @(negedge clk);
        set_req(v.idx, v.addr, v.wr, v.size, v.wdata);
        @(negedge clk);
        chk("vec_gnt", gnt, oh);
        req[v.idx] = 1'b0;
        if (v.exp_err) begin
            chk("rej_htrans_k1", htrans, 2'd0);
            chk("rej_busy_k1", busy, 1'b0);
            @(negedge clk);
            chk("rej_done", done, oh);
            chk("rej_err", err, 1'b1);
            chk("rej_htrans_k2", htrans, 2'd0);
        end else begin
            chk("vec_htrans_nonseq", htrans, 2'd2);
            chk("vec_haddr", haddr, v.addr);
            chk("vec_hsize", hsize, v.size);
            chk("vec_hwrite", hwrite, v.wr);
            chk("vec_hburst", hburst, 3'd0);
            chk("vec_busy", busy, 1'b1);
            hrdata = v.rd;
            @(negedge clk);
            chk("vec_htrans_data", htrans, 2'd0);
            chk("vec_done_early", done, '0);
            if (v.wr) chk("vec_hwdata", hwdata, v.wdata);
            @(negedge clk);
            chk("vec_done", done, oh);
            chk("vec_err", err, 1'b0);
            chk("vec_busy_end", busy, 1'b0);
            if (!v.wr) chk("vec_rdata", rdata, v.rd);
        end
    endtask

    initial begin
        int n;
        int prev;
        int idx;
        vecs[0] = '{2, 32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1, 32'h000, 1'b1, 3'd3, 32'h11111111, 32'h0,        1'b1};
        vecs[2] = '{1, 32'h102, 1'b0, 3'd2, 32'h0,        32'h0,        1'b1};
        vecs[3] = '{0, 32'h044, 1'b0, 3'd2, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[4] = '{3, 32'h006, 1'b1, 3'd1, 32'h0000BEEF, 32'h0,        1'b0};
        vecs[5] = '{3, 32'h003, 1'b0, 3'd1, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{1, 32'h007, 1'b1, 3'd0, 32'h000000A5, 32'h0,        1'b0};
        vecs[7] = '{2, 32'h008, 1'b0, 3'd4, 32'h0,        32'h0,        1'b1};

        reset     = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_write = '0;
        req_size  = '0;
        req_wdata = '0;
        hready    = 1'b1;
        hrdata    = '0;

        repeat (2) @(negedge clk);
        chk("rst_htrans", htrans, 2'd0);
        chk("rst_hburst", hburst, 3'd0);
        chk("rst_haddr", haddr, '0);
        chk("rst_hsize", hsize, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt, '0);
        chk("rst_done", done, '0);
        chk("rst_rdata", rdata, '0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Read at 0x40 with three DATA wait states.
        @(negedge clk);
        set_req(0, 32'h40, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        chk("ws_gnt", gnt, 4'b0001);
        chk("ws_nonseq", htrans, 2'd2);
        chk("ws_haddr_k1", haddr, 32'h40);
        req[0] = 1'b0;
        @(negedge clk);
        chk("ws_data", htrans, 2'd0);
        hready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ws_done_wait", done, '0);
            chk("ws_haddr_hold", haddr, 32'h40);
            chk("ws_hsize_hold", hsize, 3'd2);
            chk("ws_hwrite_hold", hwrite, 1'b0);
            chk("ws_busy_wait", busy, 1'b1);
        end
        @(negedge clk);
        chk("ws_done_k5", done, '0);
        hready = 1'b1;
        hrdata = 32'h12345678;
        @(negedge clk);
        chk("ws_done_k6", done, 4'b0001);
        chk("ws_rdata", rdata, 32'h12345678);
        chk("ws_err", err, 1'b0);

        // Write with two address-phase stall cycles.
        @(negedge clk);
        set_req(3, 32'h200, 1'b1, 3'd2, 32'hA5A50003);
        @(negedge clk);
        chk("st_gnt", gnt, 4'b1000);
        req[3] = 1'b0;
        hready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) hready = 1'b1;
            chk("st_nonseq", htrans, 2'd2);
            chk("st_haddr", haddr, 32'h200);
            chk("st_hsize", hsize, 3'd2);
            chk("st_hwrite", hwrite, 1'b1);
            @(negedge clk);
        end
        chk("st_data", htrans, 2'd0);
        chk("st_hwdata", hwdata, 32'hA5A50003);
        chk("st_done_early", done, '0);
        @(negedge clk);
        chk("st_done", done, 4'b1000);

        // Reset while stalled in DATA; ptr was advanced past 2 before the reset.
        @(negedge clk);
        set_req(2, 32'h10, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        chk("rm_gnt", gnt, 4'b0100);
        req[2] = 1'b0;
        @(negedge clk);
        chk("rm_in_data", busy, 1'b1);
        hready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rm_htrans_async", htrans, 2'd0);
        chk("rm_busy_async", busy, 1'b0);
        @(negedge clk);
        chk("rm_done0", done, '0);
        hready = 1'b1;
        @(negedge clk);
        chk("rm_done1", done, '0);
        reset = 1'b0;

        // All requesters held high: grants must rotate 0,1,2,3 from ptr=0.
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 4), 1'b0, 3'd2, 32'h0);
        n    = 0;
        prev = -1;
        for (int c = 0; c < 100 && n < 12; c++) begin
            @(negedge clk);
            chk("rr_no_done_overlap", ((|gnt) && (|done)) ? 1 : 0, 0);
            if (|gnt) begin
                idx = -1;
                for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
                chk("rr_onehot", $countones(gnt), 1);
                chk("rr_order", idx, n % N);
                chk("rr_b2b", (idx == prev) ? 1 : 0, 0);
                prev = idx;
                n++;
            end
        end
        chk("rr_count", n, 12);
        req = '0;
        repeat (5) @(negedge clk);
        chk("final_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
